// File: rtl/reg_writeback_unit_if.sv
// Signal bundle between the pipeline and the register-file write-back unit.
// The master modport is the pipeline side, the slave modport is the unit.
interface reg_writeback_unit_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5
);
  // ALU result stream
  logic                    alu_we;
  logic [AW-1:0]           alu_a3;
  logic [DW-1:0]           alu_wd;
  // Load issue and memory return
  logic                    ld_issue;
  logic [AW-1:0]           ld_a3;
  logic                    mem_valid;
  logic [AW-1:0]           mem_a3;
  logic [DW-1:0]           mem_rd;
  logic                    mem_ready;
  // Register-file write port
  logic                    we3;
  logic [AW-1:0]           a3;
  logic [DW-1:0]           wd3;
  // Decode-stage scoreboard lookup
  logic [AW-1:0]           q_a1;
  logic [AW-1:0]           q_a2;
  logic                    busy1;
  logic                    busy2;
  // Status
  logic [$clog2(DEPTH):0]  fifo_cnt;
  logic                    err;

  modport master (
    output alu_we, alu_a3, alu_wd, ld_issue, ld_a3, mem_valid, mem_a3, mem_rd, q_a1, q_a2,
    input  mem_ready, we3, a3, wd3, busy1, busy2, fifo_cnt, err
  );

  modport slave (
    input  alu_we, alu_a3, alu_wd, ld_issue, ld_a3, mem_valid, mem_a3, mem_rd, q_a1, q_a2,
    output mem_ready, we3, a3, wd3, busy1, busy2, fifo_cnt, err
  );
endinterface

// File: rtl/reg_writeback_unit.sv
// Merges single-cycle ALU results and buffered load returns onto the register
// file's single write port, and tracks registers with loads still in flight.
module reg_writeback_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  reg_writeback_unit_if.slave bus
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned NREG = 1 << AW;

  // Load-return FIFO storage and pointers
  logic [AW-1:0]   fifo_a3_q [DEPTH];
  logic [DW-1:0]   fifo_wd_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [CW-1:0]   cnt_q;

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  logic            err_q;
  logic            err_set;

  logic            we3_q;
  logic [AW-1:0]   a3_q;
  logic [DW-1:0]   wd3_q;

  logic            mem_ready;
  logic            alu_wr;
  logic            accept;
  logic            push;
  logic            pop;
  logic [AW-1:0]   head_a3;
  logic [DW-1:0]   head_wd;
  logic            in_fifo;
  logic [PW-1:0]   off;

  // Ready is forced low during reset and never looks at this cycle's pop.
  assign mem_ready = rst_n && (cnt_q < CW'(DEPTH));
  assign alu_wr    = bus.alu_we && (bus.alu_a3 != '0);
  assign accept    = bus.mem_valid && mem_ready;
  assign push      = accept && (bus.mem_a3 != '0);
  assign pop       = !alu_wr && (cnt_q != '0);
  assign head_a3   = fifo_a3_q[rd_ptr_q];
  assign head_wd   = fifo_wd_q[rd_ptr_q];

  // Does an occupied FIFO slot already hold the returning destination?
  always_comb begin
    in_fifo = 1'b0;
    off     = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      off = PW'(i) - rd_ptr_q;
      if ((CW'(off) < cnt_q) && (fifo_a3_q[i] == bus.mem_a3)) begin
        in_fifo = 1'b1;
      end
    end
  end

  // Clear on pop first so a same-edge issue to that register wins.
  always_comb begin
    pending_d = pending_q;
    if (pop) begin
      pending_d[head_a3] = 1'b0;
    end
    if (bus.ld_issue && (bus.ld_a3 != '0)) begin
      pending_d[bus.ld_a3] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    err_set = 1'b0;
    if (bus.ld_issue && (bus.ld_a3 != '0) && pending_q[bus.ld_a3] &&
        !(pop && (head_a3 == bus.ld_a3))) begin
      err_set = 1'b1;
    end
    if (push && !pending_q[bus.mem_a3] && !in_fifo) begin
      err_set = 1'b1;
    end
    if (alu_wr && pending_q[bus.alu_a3]) begin
      err_set = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_a3_q[i] <= '0;
        fifo_wd_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        fifo_a3_q[wr_ptr_q] <= bus.mem_a3;
        fifo_wd_q[wr_ptr_q] <= bus.mem_rd;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // ALU results take priority; the FIFO drains whenever the ALU is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3_q <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
    end else if (alu_wr) begin
      we3_q <= 1'b1;
      a3_q  <= bus.alu_a3;
      wd3_q <= bus.alu_wd;
    end else if (pop) begin
      we3_q <= 1'b1;
      a3_q  <= head_a3;
      wd3_q <= head_wd;
    end else begin
      we3_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_q | err_set;
    end
  end

  assign bus.mem_ready = mem_ready;
  assign bus.we3       = we3_q;
  assign bus.a3        = a3_q;
  assign bus.wd3       = wd3_q;
  assign bus.busy1     = pending_q[bus.q_a1];
  assign bus.busy2     = pending_q[bus.q_a2];
  assign bus.fifo_cnt  = cnt_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Self-checking bench for reg_writeback_unit: directed scenarios plus a random
// phase, all compared against a queue-based reference model.
module tb_reg_writeback_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_writeback_unit_if #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) bus ();

  reg_writeback_unit #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [AW-1:0] a3;
    logic [DW-1:0] wd;
  } ent_t;

  // Reference model state
  ent_t          q[$];
  bit            pend[32];
  bit            m_err;
  bit            m_we3;
  logic [AW-1:0] m_a3;
  logic [DW-1:0] m_wd3;
  bit            m_acc;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    bus.alu_we    = 1'b0;
    bus.alu_a3    = '0;
    bus.alu_wd    = '0;
    bus.ld_issue  = 1'b0;
    bus.ld_a3     = '0;
    bus.mem_valid = 1'b0;
    bus.mem_a3    = '0;
    bus.mem_rd    = '0;
  endtask

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    m_err = 1'b0;
    m_we3 = 1'b0;
    m_a3  = '0;
    m_wd3 = '0;
    m_acc = 1'b0;
  endfunction

  // One rising edge of the behavioural model, from the inputs currently driven.
  function automatic void model_step();
    bit   alu_wr, pop, inq;
    ent_t h;
    ent_t e;
    alu_wr = bus.alu_we && (bus.alu_a3 != 0);
    m_acc  = bus.mem_valid && (q.size() < int'(DEPTH));
    pop    = !alu_wr && (q.size() > 0);
    inq    = 1'b0;
    foreach (q[i]) if (q[i].a3 == bus.mem_a3) inq = 1'b1;
    if (bus.ld_issue && bus.ld_a3 != 0 && pend[bus.ld_a3] && !(pop && q[0].a3 == bus.ld_a3))
      m_err = 1'b1;
    if (m_acc && bus.mem_a3 != 0 && !pend[bus.mem_a3] && !inq) m_err = 1'b1;
    if (alu_wr && pend[bus.alu_a3]) m_err = 1'b1;
    if (alu_wr) begin
      m_we3 = 1'b1;
      m_a3  = bus.alu_a3;
      m_wd3 = bus.alu_wd;
    end else if (pop) begin
      h     = q.pop_front();
      m_we3 = 1'b1;
      m_a3  = h.a3;
      m_wd3 = h.wd;
      pend[h.a3] = 1'b0;
    end else begin
      m_we3 = 1'b0;
    end
    if (bus.ld_issue && bus.ld_a3 != 0) pend[bus.ld_a3] = 1'b1;
    if (m_acc && bus.mem_a3 != 0) begin
      e.a3 = bus.mem_a3;
      e.wd = bus.mem_rd;
      q.push_back(e);
    end
  endfunction

  // Check combinational outputs, clock once, then check registered outputs.
  task automatic cycle();
    #1;
    check("mem_ready", 64'(bus.mem_ready), 64'(q.size() < int'(DEPTH)));
    check("busy1", 64'(bus.busy1), 64'(pend[bus.q_a1]));
    check("busy2", 64'(bus.busy2), 64'(pend[bus.q_a2]));
    @(posedge clk);
    model_step();
    #1;
    check("we3", 64'(bus.we3), 64'(m_we3));
    check("a3", 64'(bus.a3), 64'(m_a3));
    check("wd3", 64'(bus.wd3), 64'(m_wd3));
    check("fifo_cnt", 64'(bus.fifo_cnt), 64'(q.size()));
    check("err", 64'(bus.err), 64'(m_err));
  endtask

  task automatic do_reset();
    set_idle();
    #2 rst_n = 1'b0;
    #1;
    check("rst_we3", 64'(bus.we3), 64'(0));
    check("rst_cnt", 64'(bus.fifo_cnt), 64'(0));
    check("rst_ready", 64'(bus.mem_ready), 64'(0));
    check("rst_err", 64'(bus.err), 64'(0));
    check("rst_busy1", 64'(bus.busy1), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic issue(input int r);
    set_idle();
    bus.ld_issue = 1'b1;
    bus.ld_a3    = AW'(r);
    cycle();
  endtask

  task automatic ret(input int r, input logic [DW-1:0] d, input bit alu);
    set_idle();
    bus.mem_valid = 1'b1;
    bus.mem_a3    = AW'(r);
    bus.mem_rd    = d;
    if (alu) begin
      bus.alu_we = 1'b1;
      bus.alu_a3 = AW'(1);
      bus.alu_wd = 32'hA1A1_0000 | DW'(r);
    end
    cycle();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      set_idle();
      cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, idx, bound;
    bit iss;
    int outst[$];

    set_idle();
    bus.q_a1 = AW'(5);
    bus.q_a2 = AW'(6);
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Reset mid-operation: three returns parked in the FIFO behind ALU writes.
    issue(5); issue(6); issue(7);
    ret(5, 32'h5555_0005, 1'b1);
    ret(6, 32'h6666_0006, 1'b1);
    ret(7, 32'h7777_0007, 1'b1);
    check("mid_cnt", 64'(bus.fifo_cnt), 64'(3));
    check("mid_busy", 64'(bus.busy1), 64'(1));
    do_reset();

    // Single load.
    bus.q_a1 = AW'(8);
    issue(8);
    check("sl_busy_hi", 64'(bus.busy1), 64'(1));
    idle_cycles(1);
    ret(8, 32'hDEAD_BEEF, 1'b0);
    idle_cycles(1);
    check("sl_we3", 64'(bus.we3), 64'(1));
    check("sl_a3", 64'(bus.a3), 64'(8));
    check("sl_wd3", 64'(bus.wd3), 64'hDEAD_BEEF);
    check("sl_busy_lo", 64'(bus.busy1), 64'(0));

    // Arbitration: ALU r1..r3 while two returns queue up.
    issue(20); issue(21);
    for (int i = 1; i <= 3; i++) begin
      set_idle();
      bus.alu_we = 1'b1;
      bus.alu_a3 = AW'(i);
      bus.alu_wd = DW'(32'h100 + i);
      if (i < 3) begin
        bus.mem_valid = 1'b1;
        bus.mem_a3    = AW'(19 + i);
        bus.mem_rd    = DW'(32'h2000 + i);
      end
      cycle();
      check("arb_alu_a3", 64'(bus.a3), 64'(i));
    end
    check("arb_cnt2", 64'(bus.fifo_cnt), 64'(2));
    idle_cycles(1);
    check("arb_ld1", 64'(bus.a3), 64'(20));
    check("arb_cnt1", 64'(bus.fifo_cnt), 64'(1));
    idle_cycles(1);
    check("arb_ld2", 64'(bus.a3), 64'(21));
    check("arb_cnt0", 64'(bus.fifo_cnt), 64'(0));

    // Full FIFO and wrap.
    bus.q_a1 = AW'(11);
    for (int i = 11; i <= 15; i++) issue(i);
    for (int i = 11; i <= 14; i++) ret(i, DW'(32'hF000 + i), 1'b1);
    set_idle();
    bus.alu_we = 1'b1; bus.alu_a3 = AW'(1); bus.alu_wd = 32'h0BAD_0001;
    bus.mem_valid = 1'b1; bus.mem_a3 = AW'(15); bus.mem_rd = 32'hF00F;
    #1;
    check("full_ready", 64'(bus.mem_ready), 64'(0));
    cycle();
    check("full_cnt", 64'(bus.fifo_cnt), 64'(4));
    bus.alu_we = 1'b0;
    bound = 0;
    m_acc = 1'b0;
    while (!m_acc && bound < 5) begin
      cycle();
      bound++;
    end
    check("full_accept", 64'(m_acc), 64'(1));
    set_idle();
    for (int i = 16; i <= 21; i++) issue(i);
    for (int i = 16; i <= 21; i++) ret(i, DW'(32'hC000 + i), 1'b0);
    idle_cycles(8);
    check("wrap_err", 64'(bus.err), 64'(0));
    check("wrap_empty", 64'(bus.fifo_cnt), 64'(0));

    // Register 0 is never written nor tracked.
    bus.q_a1 = AW'(0);
    set_idle();
    bus.alu_we = 1'b1; bus.alu_a3 = '0; bus.alu_wd = 32'h1234;
    bus.ld_issue = 1'b1; bus.ld_a3 = '0;
    bus.mem_valid = 1'b1; bus.mem_a3 = '0; bus.mem_rd = 32'h5678;
    cycle();
    check("r0_we3", 64'(bus.we3), 64'(0));
    idle_cycles(1);
    check("r0_we3b", 64'(bus.we3), 64'(0));
    check("r0_busy", 64'(bus.busy1), 64'(0));
    check("r0_cnt", 64'(bus.fifo_cnt), 64'(0));
    check("r0_err", 64'(bus.err), 64'(0));

    // Error (a): double issue.
    do_reset();
    issue(9);
    check("erra_first", 64'(bus.err), 64'(0));
    issue(9);
    check("erra_set", 64'(bus.err), 64'(1));
    idle_cycles(3);
    check("erra_sticky", 64'(bus.err), 64'(1));
    do_reset();

    // Error (b): unsolicited return.
    ret(10, 32'hAAAA_000A, 1'b0);
    check("errb_set", 64'(bus.err), 64'(1));
    idle_cycles(2);
    do_reset();

    // Random phase with well-formed traffic.
    for (int c = 0; c < 400; c++) begin
      set_idle();
      bus.q_a1 = AW'($urandom_range(0, 31));
      bus.q_a2 = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) begin
        r = int'($urandom_range(0, 31));
        bus.alu_we = 1'b1;
        bus.alu_a3 = pend[r] ? AW'(0) : AW'(r);
        bus.alu_wd = $urandom;
      end
      iss = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        r = int'($urandom_range(1, 31));
        if (!pend[r]) begin
          iss = 1'b1;
          bus.ld_issue = 1'b1;
          bus.ld_a3 = AW'(r);
        end
      end
      idx = -1;
      if (outst.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = int'($urandom_range(0, outst.size() - 1));
        bus.mem_valid = 1'b1;
        bus.mem_a3    = AW'(outst[idx]);
        bus.mem_rd    = $urandom;
      end
      cycle();
      if (idx >= 0 && m_acc) outst.delete(idx);
      if (iss) outst.push_back(r);
    end
    check("rand_err", 64'(bus.err), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
